// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   hazard_state_t : sequencing state (RUN, LU_STALL, MEM_WAIT)
//   ctrl_vec_t     : per-stage stall/flush controls plus PC redirect select
//   CTRL_NONE      : all controls inactive
//   ctrl_*()       : canned control patterns for each hazard response
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
        logic pc_sel;
    } ctrl_vec_t;

    localparam ctrl_vec_t CTRL_NONE = '0;

    // Memory not ready: freeze IF..MEM, drain a bubble into WB.
    function automatic ctrl_vec_t ctrl_mem_wait();
        ctrl_vec_t c;
        c           = CTRL_NONE;
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.stall_mem = 1'b1;
        c.flush_wb  = 1'b1;
        return c;
    endfunction

    // Load-use: freeze IF..EX, bubble into MEM so the load advances.
    function automatic ctrl_vec_t ctrl_load_use();
        ctrl_vec_t c;
        c           = CTRL_NONE;
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.flush_mem = 1'b1;
        return c;
    endfunction

    // Taken branch: redirect PC and squash the two younger instructions.
    function automatic ctrl_vec_t ctrl_branch();
        ctrl_vec_t c;
        c          = CTRL_NONE;
        c.pc_sel   = 1'b1;
        c.flush_id = 1'b1;
        c.flush_ex = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters (stall cycles, redirect events).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   stall_en_i    : count one stall cycle
//   flush_en_i    : count one redirect event
//   stall_cnt_o   : PERF_W stall-cycle count, wraps
//   flush_cnt_o   : PERF_W redirect count, wraps
module hazard_perf_cnt #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_en_i,
    input  logic              flush_en_i,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    // Free-running wrap-around increments.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_en_i) stall_d = stall_q + PERF_W'(1);
        if (flush_en_i) flush_d = flush_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard responder for the 5-stage RV32 core.
// Sequences memory-wait and load-use stalls and branch redirects; the
// stall/flush/pc_sel controls are combinational from state and inputs so
// they act in the cycle the hazard is seen.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   load_use_hazard            : load in MEM feeds the EX instruction
//   branch_taken_ex            : EX resolved a taken branch/jump
//   mem_req, mem_ready         : MEM access active / completing
//   stall_if/id/ex/mem         : hold PC and pipeline registers
//   flush_id/ex/mem/wb         : inject bubbles
//   pc_sel                     : PC takes EX redirect target
//   mem_timeout                : sticky, a wait lasted MEM_TIMEOUT cycles
//   perf_stall_cycles          : cycles with stall_if high
//   perf_flush_count           : redirect events
// Build option: HAZARD_PERF_EN enables the perf counters; otherwise the
// perf ports read zero and no counter flops exist.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_use_hazard,
    input  logic              branch_taken_ex,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              flush_wb,
    output logic              pc_sel,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_count
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    hazard_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             wait_start_c;
    ctrl_vec_t        ctrl_raw_c;
    ctrl_vec_t        ctrl_c;

    assign wait_start_c = mem_req & ~mem_ready;

    // Next state, wait counter and control response; memory > load-use > branch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_raw_c = CTRL_NONE;
        case (state_q)
            RUN, LU_STALL: begin
                if (wait_start_c) begin
                    ctrl_raw_c = ctrl_mem_wait();
                    state_d    = MEM_WAIT;
                    cnt_d      = CNT_W'(1);
                end else if (load_use_hazard && (state_q == RUN)) begin
                    // Branch operands are stale here, so a branch is ignored.
                    ctrl_raw_c = ctrl_load_use();
                    state_d    = LU_STALL;
                end else begin
                    state_d = RUN;
                    if (branch_taken_ex) ctrl_raw_c = ctrl_branch();
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    ctrl_raw_c = ctrl_mem_wait();
                    if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                    if (branch_taken_ex) ctrl_raw_c = ctrl_branch();
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        timeout_d = timeout_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Controls are forced inactive the moment reset asserts.
    assign ctrl_c = rst_n ? ctrl_raw_c : CTRL_NONE;

    assign stall_if    = ctrl_c.stall_if;
    assign stall_id    = ctrl_c.stall_id;
    assign stall_ex    = ctrl_c.stall_ex;
    assign stall_mem   = ctrl_c.stall_mem;
    assign flush_id    = ctrl_c.flush_id;
    assign flush_ex    = ctrl_c.flush_ex;
    assign flush_mem   = ctrl_c.flush_mem;
    assign flush_wb    = ctrl_c.flush_wb;
    assign pc_sel      = ctrl_c.pc_sel;
    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_en_i  (ctrl_c.stall_if),
        .flush_en_i  (ctrl_c.pc_sel),
        .stall_cnt_o (perf_stall_cycles),
        .flush_cnt_o (perf_flush_count)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// reset/timeout/perf sequences, and a randomized run against a reference model.
module tb_hazard_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_PERF_W  = 32;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Control bus order: stall_if,id,ex,mem, flush_id,ex,mem,wb, pc_sel
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_BR   = 9'b000011001;
    localparam logic [8:0] C_LU   = 9'b111000100;
    localparam logic [8:0] C_MW   = 9'b111100010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use_hazard = 1'b0;
    logic branch_taken_ex = 1'b0;
    logic mem_req = 1'b0;
    logic mem_ready = 1'b0;
    logic stall_if, stall_id, stall_ex, stall_mem;
    logic flush_id, flush_ex, flush_mem, flush_wb;
    logic pc_sel, mem_timeout;
    logic [TB_PERF_W-1:0] perf_stall_cycles, perf_flush_count;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .PERF_W      (TB_PERF_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_use_hazard   (load_use_hazard),
        .branch_taken_ex   (branch_taken_ex),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .stall_ex          (stall_ex),
        .stall_mem         (stall_mem),
        .flush_id          (flush_id),
        .flush_ex          (flush_ex),
        .flush_mem         (flush_mem),
        .flush_wb          (flush_wb),
        .pc_sel            (pc_sel),
        .mem_timeout       (mem_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic       lu, br, req, rdy;
        logic [8:0] ctrl;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: waiting for memory, one-cycle load-use cooldown,
    // length of the current wait, sticky timeout and event totals.
    bit      m_waiting;
    bit      m_cooldown;
    int      m_wait_len;
    bit      m_to;
    longint  m_ps;
    longint  m_pf;

    task automatic model_reset();
        m_waiting  = 0;
        m_cooldown = 0;
        m_wait_len = 0;
        m_to       = 0;
        m_ps       = 0;
        m_pf       = 0;
    endtask

    // Expected controls for this cycle; advances model to the next cycle.
    task automatic model_step(input bit lu, input bit br, input bit req,
                              input bit rdy, output logic [8:0] exp);
        bit took_lu;
        took_lu = 0;
        exp     = C_NONE;
        if (m_waiting) begin
            if (!rdy) begin
                exp        = C_MW;
                m_wait_len = m_wait_len + 1;
            end else begin
                m_waiting  = 0;
                m_wait_len = 0;
                if (br) exp = C_BR;
            end
        end else if (req && !rdy) begin
            exp        = C_MW;
            m_waiting  = 1;
            m_wait_len = 1;
        end else if (lu && !m_cooldown) begin
            exp     = C_LU;
            took_lu = 1;
        end else if (br) begin
            exp = C_BR;
        end
        m_cooldown = took_lu;
        if (m_wait_len >= int'(TB_TIMEOUT)) m_to = 1;
        if (exp[8]) m_ps = m_ps + 1;
        if (exp[0]) m_pf = m_pf + 1;
    endtask

    task automatic check(input string name, input logic [8:0] exp_ctrl,
                         input logic exp_to, input bit chk_perf,
                         input logic [TB_PERF_W-1:0] exp_ps,
                         input logic [TB_PERF_W-1:0] exp_pf);
        logic [8:0] act;
        bit bad;
        act = {stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb, pc_sel};
        vectors = vectors + 1;
        bad = (act !== exp_ctrl) || (mem_timeout !== exp_to);
        if (chk_perf && ((perf_stall_cycles !== exp_ps) || (perf_flush_count !== exp_pf)))
            bad = 1;
        if (bad) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got ctrl=%b to=%b ps=%0d pf=%0d, want ctrl=%b to=%b ps=%0d pf=%0d (perf checked=%0d)",
                     name, act, mem_timeout, perf_stall_cycles, perf_flush_count,
                     exp_ctrl, exp_to, exp_ps, exp_pf, chk_perf);
        end
    endtask

    task automatic drive(input bit lu, input bit br, input bit req, input bit rdy);
        @(negedge clk);
        load_use_hazard = lu;
        branch_taken_ex = br;
        mem_req         = req;
        mem_ready       = rdy;
        #1;
    endtask

    // Reset with hazard inputs active to show the controls are forced to 0.
    task automatic do_reset(input string name);
        @(negedge clk);
        load_use_hazard = 1;
        branch_taken_ex = 1;
        mem_req         = 1;
        mem_ready       = 0;
        rst_n           = 0;
        #1;
        check(name, C_NONE, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        load_use_hazard = 0;
        branch_taken_ex = 0;
        mem_req         = 0;
        mem_ready       = 0;
        rst_n           = 1;
        model_reset();
    endtask

    task automatic add_vec(input string n, input bit lu, input bit br, input bit req,
                           input bit rdy, input logic [8:0] c, input bit to);
        vec_t v;
        v.name = n; v.lu = lu; v.br = br; v.req = req; v.rdy = rdy;
        v.ctrl = c; v.to = to;
        tbl.push_back(v);
    endtask

    initial begin
        logic [8:0] exp;
        bit lu, br, req, rdy;
        logic [TB_PERF_W-1:0] pre_ps, pre_pf;
        bit pre_to;

        //        name           lu br rq rd  ctrl    to
        add_vec("idle",          0, 0, 0, 0, C_NONE, 0);
        add_vec("branch",        0, 1, 0, 0, C_BR,   0);
        add_vec("branch_1cyc",   0, 0, 0, 0, C_NONE, 0);
        add_vec("lu_1",          1, 0, 0, 0, C_LU,   0);
        add_vec("lu_2_ignored",  1, 0, 0, 0, C_NONE, 0);
        add_vec("lu_3",          1, 0, 0, 0, C_LU,   0);
        add_vec("lu_done",       0, 0, 0, 0, C_NONE, 0);
        add_vec("lu_beats_br",   1, 1, 0, 0, C_LU,   0);
        add_vec("br_in_lustall", 0, 1, 0, 0, C_BR,   0);
        add_vec("req_rdy_same",  0, 0, 1, 1, C_NONE, 0);
        add_vec("mw_beats_lu",   1, 0, 1, 0, C_MW,   0);
        add_vec("mw_ignore_br",  0, 1, 1, 0, C_MW,   0);
        add_vec("mw_rel_br",     0, 1, 1, 1, C_BR,   0);
        add_vec("idle2",         0, 0, 0, 0, C_NONE, 0);
        add_vec("mw5_1",         0, 0, 1, 0, C_MW,   0);
        add_vec("mw5_2",         0, 0, 1, 0, C_MW,   0);
        add_vec("mw5_3",         0, 0, 1, 0, C_MW,   0);
        add_vec("mw5_4",         0, 0, 1, 0, C_MW,   0);
        add_vec("mw5_5",         0, 0, 1, 0, C_MW,   1);
        add_vec("mw5_release",   0, 0, 1, 1, C_NONE, 1);
        add_vec("idle3",         0, 0, 0, 0, C_NONE, 1);
        add_vec("lu_then",       1, 0, 0, 0, C_LU,   1);
        add_vec("lustall_to_mw", 1, 0, 1, 0, C_MW,   1);
        add_vec("mw_rel_lu_ign", 1, 0, 1, 1, C_NONE, 1);
        add_vec("lu_after_mw",   1, 0, 0, 0, C_LU,   1);
        add_vec("idle4",         0, 0, 0, 0, C_NONE, 1);

        do_reset("reset_init");
        foreach (tbl[i]) begin
            drive(tbl[i].lu, tbl[i].br, tbl[i].req, tbl[i].rdy);
            check(tbl[i].name, tbl[i].ctrl, tbl[i].to, 1'b0, '0, '0);
        end

        // Branch redirect counted once in perf.
        do_reset("reset_br");
        drive(0, 1, 0, 0);
        check("perf_br", C_BR, 1'b0, 1'b1, '0, '0);
        drive(0, 0, 0, 0);
        check("perf_br_after", C_NONE, 1'b0, 1'b1, '0, TB_PERF_W'(PERF_ON));

        // Five-cycle memory wait counted as five stall cycles.
        do_reset("reset_mw");
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            check("perf_mw", C_MW, 1'(i >= 4), 1'b1, TB_PERF_W'(PERF_ON ? i : 0), '0);
        end
        drive(0, 0, 1, 1);
        check("perf_mw_rel", C_NONE, 1'b1, 1'b1, TB_PERF_W'(PERF_ON ? 5 : 0), '0);

        // Ten-cycle wait: timeout after the 4th, sticky through release, cleared by reset.
        do_reset("reset_tmo");
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 0);
            check("tmo_wait", C_MW, 1'(i >= 4), 1'b0, '0, '0);
        end
        drive(0, 0, 1, 1);
        check("tmo_release", C_NONE, 1'b1, 1'b0, '0, '0);
        drive(0, 0, 0, 0);
        check("tmo_sticky", C_NONE, 1'b1, 1'b0, '0, '0);
        do_reset("tmo_cleared");

        // Reset pulsed asynchronously in the 3rd wait cycle.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            check("rmw_wait", C_MW, 1'b0, 1'b0, '0, '0);
        end
        #2 rst_n = 0;
        #1 check("rmw_async_rst", C_NONE, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        mem_req = 0;
        rst_n   = 1;
        model_reset();
        drive(0, 0, 0, 0);
        check("rmw_run_idle", C_NONE, 1'b0, 1'b0, '0, '0);
        drive(1, 0, 0, 0);
        check("rmw_run_lu", C_LU, 1'b0, 1'b0, '0, '0);

        // Randomized traffic against the reference model.
        do_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            lu  = ($urandom_range(0, 99) < 30);
            br  = ($urandom_range(0, 99) < 30);
            req = ($urandom_range(0, 99) < 45);
            rdy = ($urandom_range(0, 99) < 60);
            drive(lu, br, req, rdy);
            pre_to = m_to;
            pre_ps = PERF_ON ? TB_PERF_W'(m_ps) : '0;
            pre_pf = PERF_ON ? TB_PERF_W'(m_pf) : '0;
            model_step(lu, br, req, rdy, exp);
            check("random", exp, pre_to, 1'b1, pre_ps, pre_pf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard responder for the 5-stage RV32 core.
- Consumes the load-use request from the EX forwarding unit, branch/jump redirects from EX, and the data-memory ready handshake from MEM.
- Drives per-stage stall (hold) and flush (bubble) controls plus the PC redirect select.
- Sits beside the pipeline registers; owns the sequencing of multi-cycle stalls so forwarding logic stays purely combinational.

Parameters:
- MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout asserts; must be >= 1.
- PERF_W, 32, width of performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- load_use_hazard  in  1  load in MEM feeds a source of the EX instruction
- branch_taken_ex  in  1  EX resolved a taken branch/jump (redirect required)
- mem_req  in  1  MEM-stage instruction is an active load/store
- mem_ready  in  1  data memory completes the MEM access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register
- stall_mem  out  1  hold EX/MEM register
- flush_id  out  1  load bubble into IF/ID
- flush_ex  out  1  load bubble into ID/EX
- flush_mem  out  1  load bubble into EX/MEM
- flush_wb  out  1  load bubble into MEM/WB
- pc_sel  out  1  1 = PC takes EX redirect target
- mem_timeout  out  1  sticky: a MEM_WAIT lasted MEM_TIMEOUT cycles
- perf_stall_cycles  out  PERF_W  cycles with stall_if high
- perf_flush_count  out  PERF_W  redirect events

Behaviour:
- Reset: state RUN, timeout counter 0, mem_timeout 0, perf counters 0. All stall/flush/pc_sel outputs are 0 while rst_n is low.
- State is registered. Stall/flush/pc_sel are combinational from state and inputs so they act in the same cycle.
- States: RUN, LU_STALL, MEM_WAIT. Event priority: memory wait > load-use > branch.
- RUN, mem_req=1 and mem_ready=0:
  - Assert stall_if/id/ex/mem and flush_wb.
  - Next state MEM_WAIT; counter loads 1.
- RUN, load_use_hazard=1 (memory not waiting):
  - Assert stall_if/id/ex and flush_mem.
  - Next state LU_STALL.
  - branch_taken_ex is ignored this cycle because the branch's operands are invalid.
- RUN, branch_taken_ex=1 only: assert pc_sel, flush_id, flush_ex for exactly that cycle; stay RUN.
- LU_STALL:
  - Lasts exactly one cycle. load_use_hazard is ignored.
  - Memory and branch rules are evaluated as in RUN, except load-use.
  - Next state RUN, unless a memory wait starts, in which case MEM_WAIT.
- MEM_WAIT:
  - Hold the full stall set plus flush_wb until mem_ready=1.
  - On mem_ready: deassert all stalls that cycle. If branch_taken_ex=1, apply pc_sel/flush_id/flush_ex in the same cycle. Next state RUN.
  - branch_taken_ex and load_use_hazard are otherwise ignored in this state.
- Timeout counter:
  - Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - mem_timeout sets when the count reaches MEM_TIMEOUT and clears only on reset.
  - The stall continues; there is no abort.
- mem_req=1 with mem_ready=1 in the same cycle: no stall.
- Reset asserted mid-stall: immediate return to RUN with outputs 0; no held state survives.

Optional Feature:
- HAZARD_PERF_EN defined:
  - perf_stall_cycles increments on every cycle with stall_if=1.
  - perf_flush_count increments on every cycle with pc_sel=1.
  - Both wrap modulo 2^PERF_W.
- Undefined: both ports are present but tied to 0, and no counter flops are built.

Decomposition:
- hazard_pkg:
  - hazard_state_t enum (RUN, LU_STALL, MEM_WAIT).
  - ctrl_vec_t packed struct grouping the four stalls, four flushes and pc_sel.
  - Default ctrl constant CTRL_NONE.
- One sub-module, hazard_perf_cnt: two PERF_W counters with enable inputs, instantiated only under HAZARD_PERF_EN.

Test Plan:
- Branch: branch_taken_ex=1 for one cycle in RUN -> pc_sel, flush_id and flush_ex high for exactly 1 cycle, no stalls; perf_flush_count=1 (perf build).
- Load-use held: load_use_hazard held high for 3 cycles -> stall_if/id/ex and flush_mem for 1 cycle, nothing the 2nd cycle (LU_STALL ignores), stall again on the 3rd.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles then 1 -> full stall and flush_wb for 5 cycles, released on the 6th; perf_stall_cycles=5.
- Simultaneous events: load_use_hazard=1 and branch_taken_ex=1 together -> load-use response only, pc_sel=0. Then mem_req=1, mem_ready=0 with load_use_hazard=1 -> MEM_WAIT response wins.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 for 10 cycles -> mem_timeout rises after the 4th wait cycle, stays high after release, clears on rst_n=0.
- Reset mid-wait: rst_n pulsed low in the 3rd MEM_WAIT cycle -> all outputs 0 asynchronously, state RUN after release.
